// File: rtl/pmu_pkg.sv
// PMU register-map package: FSM state encoding and register-map layout
// shared between the APB register wrapper and the PMU core.
package pmu_pkg;

  // APB slave FSM states (one wait state per transfer).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_state_e;

  // Number of words needed to hold one overflow bit per counter.
  function automatic int ovf_words(input int n_counters, input int reg_width);
    return (n_counters + reg_width - 1) / reg_width;
  endfunction

  // Total register count: config + counters + overflow mask + overflow vector.
  function automatic int total_nregs(input int n_conf, input int n_counters,
                                     input int reg_width, input int overflow);
    return n_conf + n_counters + 2 * ovf_words(n_counters, reg_width) * overflow;
  endfunction

  // Default configuration of the PMU.
  localparam int DEF_REG_WIDTH   = 32;
  localparam int DEF_N_COUNTERS  = 9;
  localparam int DEF_N_CONF_REGS = 1;
  localparam int DEF_OVERFLOW    = 1;

  // Register indices of each region for the default configuration.
  localparam int BASE_CFG           = 0;
  localparam int BASE_COUNTERS      = BASE_CFG + DEF_N_CONF_REGS;
  localparam int BASE_OVERFLOW_MASK = BASE_COUNTERS + DEF_N_COUNTERS;
  localparam int BASE_OVERFLOW_VECT = BASE_OVERFLOW_MASK
                                    + ovf_words(DEF_N_COUNTERS, DEF_REG_WIDTH);

endpackage

// File: rtl/pmu_apb_regs_if.sv
// APB3 bus bundle for the PMU register wrapper. Signal names are given
// from the slave's point of view (_i into the slave, _o out of it).
interface pmu_apb_regs_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32
);
  logic                  psel_i;
  logic                  penable_i;
  logic                  pwrite_i;
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic [REG_WIDTH-1:0]  pwdata_i;
  logic [REG_WIDTH-1:0]  prdata_o;
  logic                  pready_o;
  logic                  pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/pmu_apb_fsm.sv
// APB3 slave handshake: IDLE -> WAIT -> RESP with exactly one wait state.
// Latches the transfer attributes on the setup phase and flags the cycle
// in which an access completes (xfer_o); the register file decodes it.
module pmu_apb_fsm
  import pmu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [REG_WIDTH-1:0]  pwdata_i,
  output logic                  pready_o,
  output logic                  xfer_o,
  output logic                  wr_o,
  output logic [ADDR_WIDTH-3:0] idx_o,
  output logic [REG_WIDTH-1:0]  wdata_o,
  output logic                  misalign_o
);

  apb_state_e            state_q;
  logic                  pready_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-3:0] idx_q;
  logic [REG_WIDTH-1:0]  wdata_q;
  logic                  misalign_q;

  // Access completes on the edge leaving WAIT with the enable phase present.
  assign xfer_o     = (state_q == ST_WAIT) && psel_i && penable_i;
  assign pready_o   = pready_q;
  assign wr_o       = wr_q;
  assign idx_o      = idx_q;
  assign wdata_o    = wdata_q;
  assign misalign_o = misalign_q;

  // Handshake state, registered pready and setup-phase latches.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      pready_q   <= 1'b0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pready_q <= 1'b0;
          if (psel_i && !penable_i) begin
            state_q    <= ST_WAIT;
            wr_q       <= pwrite_i;
            idx_q      <= paddr_i[ADDR_WIDTH-1:2];
            wdata_q    <= pwdata_i;
            misalign_q <= (paddr_i[1:0] != 2'b00);
          end
        end
        ST_WAIT: begin
          if (psel_i && penable_i) begin
            state_q  <= ST_RESP;
            pready_q <= 1'b1;
          end else begin
            // Master abandoned the transfer: drop it without side effects.
            state_q  <= ST_IDLE;
            pready_q <= 1'b0;
          end
        end
        ST_RESP: begin
          state_q  <= ST_IDLE;
          pready_q <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          pready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pmu_apb_regs.sv
// PMU APB register wrapper. Holds the register file shared with the PMU
// core: registers mirror the core's live values every cycle except when a
// bus write commits, after which a one-cycle wrapper_we_o strobe tells the
// core to load regs_o. Optional build macro PMU_APB_SLVERR_EN enables
// pslverr_o for out-of-range, misaligned or read-only-write accesses.
module pmu_apb_regs
  import pmu_pkg::*;
#(
  parameter int REG_WIDTH   = 32,
  parameter int N_COUNTERS  = 9,
  parameter int N_CONF_REGS = 1,
  parameter int OVERFLOW    = 1,
  parameter int ADDR_WIDTH  = 32,
  localparam int TOTAL_NREGS = total_nregs(N_CONF_REGS, N_COUNTERS, REG_WIDTH, OVERFLOW)
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  pmu_apb_regs_if.slave                         apb,
  output logic [TOTAL_NREGS-1:0][REG_WIDTH-1:0] regs_o,
  input  logic [TOTAL_NREGS-1:0][REG_WIDTH-1:0] regs_i,
  output logic                                  wrapper_we_o
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  // Everything below the overflow vector is writable; the vector is read-only.
  localparam int WR_LIMIT = BASE_CFG + N_CONF_REGS + N_COUNTERS
                          + ovf_words(N_COUNTERS, REG_WIDTH) * OVERFLOW;

  logic                  pready_s;
  logic                  xfer_s;
  logic                  wr_s;
  logic [IDX_W-1:0]      idx_s;
  logic [REG_WIDTH-1:0]  wdata_s;
  logic                  misalign_s;
  logic                  in_range_s;
  logic                  writable_s;
  logic                  err_s;
  logic                  commit_ok_s;
  logic [REG_WIDTH-1:0]  rd_data_s;

  logic [TOTAL_NREGS-1:0][REG_WIDTH-1:0] slv_reg_q, slv_reg_d;
  logic [REG_WIDTH-1:0]  prdata_q;
  logic                  pslverr_q;
  logic                  wrapper_we_q;

  pmu_apb_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_WIDTH  (REG_WIDTH)
  ) u_fsm (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .psel_i     (apb.psel_i),
    .penable_i  (apb.penable_i),
    .pwrite_i   (apb.pwrite_i),
    .paddr_i    (apb.paddr_i),
    .pwdata_i   (apb.pwdata_i),
    .pready_o   (pready_s),
    .xfer_o     (xfer_s),
    .wr_o       (wr_s),
    .idx_o      (idx_s),
    .wdata_o    (wdata_s),
    .misalign_o (misalign_s)
  );

`ifdef PMU_APB_SLVERR_EN
  // Address decode with error reporting; misaligned writes never commit.
  always_comb begin
    in_range_s  = (idx_s < IDX_W'(TOTAL_NREGS));
    writable_s  = (idx_s < IDX_W'(WR_LIMIT));
    err_s       = !in_range_s || misalign_s || (wr_s && !writable_s);
    commit_ok_s = xfer_s && wr_s && writable_s && !misalign_s;
  end
`else
  logic unused_misalign_s;
  assign unused_misalign_s = misalign_s;

  // Address decode without error reporting; byte offset is ignored.
  always_comb begin
    in_range_s  = (idx_s < IDX_W'(TOTAL_NREGS));
    writable_s  = (idx_s < IDX_W'(WR_LIMIT));
    err_s       = 1'b0;
    commit_ok_s = xfer_s && wr_s && writable_s;
  end
`endif

  // Read mux: out-of-range indices match no register and read as zero.
  always_comb begin
    rd_data_s = '0;
    for (int k = 0; k < TOTAL_NREGS; k++) begin
      rd_data_s = rd_data_s | ((idx_s == IDX_W'(k)) ? slv_reg_q[k] : '0);
    end
  end

  // Register file next state: bus write wins, then hold during the load
  // strobe so the core sees the written value, otherwise mirror the core.
  always_comb begin
    slv_reg_d = slv_reg_q;
    if (commit_ok_s) begin
      for (int k = 0; k < TOTAL_NREGS; k++) begin
        slv_reg_d[k] = (idx_s == IDX_W'(k)) ? wdata_s : slv_reg_q[k];
      end
    end else if (!wrapper_we_q) begin
      slv_reg_d = regs_i;
    end else begin
      slv_reg_d = slv_reg_q;
    end
  end

  // Register file state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      slv_reg_q <= '0;
    end else begin
      slv_reg_q <= slv_reg_d;
    end
  end

  // Registered bus response and core load strobe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
      wrapper_we_q <= 1'b0;
    end else begin
      wrapper_we_q <= commit_ok_s;
      pslverr_q    <= xfer_s ? err_s : 1'b0;
      if (xfer_s && !wr_s) begin
        prdata_q <= in_range_s ? rd_data_s : '0;
      end
    end
  end

  assign regs_o        = slv_reg_q;
  assign wrapper_we_o  = wrapper_we_q;
  assign apb.prdata_o  = prdata_q;
  assign apb.pready_o  = pready_s;
  assign apb.pslverr_o = pslverr_q;

endmodule

// File: tb/tb_pmu_apb_regs.sv
// Self-checking bench for pmu_apb_regs: a directed vector table, hand
// sequences for reset/abort/event corners and randomized transfers checked
// against a register-map model. The bench also plays the PMU core.
module tb_pmu_apb_regs;

  localparam int AW    = 32;
  localparam int RW    = 32;
  localparam int NREGS = 12;
`ifdef PMU_APB_SLVERR_EN
  localparam bit SLVERR = 1'b1;
`else
  localparam bit SLVERR = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pmu_apb_regs_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) apb_if ();

  logic [NREGS-1:0][RW-1:0] regs_o_w;
  logic [NREGS-1:0][RW-1:0] core = '0;
  logic                     we_w;

  logic        ev1      = 1'b0;
  logic        poke_en  = 1'b0;
  int          poke_idx = 0;
  logic [31:0] poke_val = 32'h0;

  pmu_apb_regs #(
    .REG_WIDTH(RW), .N_COUNTERS(9), .N_CONF_REGS(1), .OVERFLOW(1), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .apb          (apb_if),
    .regs_o       (regs_o_w),
    .regs_i       (core),
    .wrapper_we_o (we_w)
  );

  // PMU core stand-in: loads regs_o on strobe, else counts event 0 / accepts pokes.
  always @(posedge clk) begin
    if (we_w) begin
      core <= regs_o_w;
    end else begin
      if (poke_en) core[poke_idx] <= poke_val;
      if (ev1) core[1] <= core[1] + 32'd1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [NREGS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Register-map rules: what a transfer returns and how it changes the map.
  function automatic void model_step(input logic wr, input logic [31:0] addr,
                                     input logic [31:0] wdata, output logic [31:0] exp_rd,
                                     output logic exp_err, output logic exp_we);
    int  idx      = int'(addr >> 2);
    bit  in_range = (idx < NREGS);
    bit  writable = (idx < NREGS - 1);
    bit  aligned  = (addr[1:0] == 2'b00);
    exp_rd  = in_range ? model[idx] : 32'h0;
    exp_we  = 1'b0;
    if (wr) begin
      exp_we  = writable && (!SLVERR || aligned);
      exp_err = SLVERR && (!in_range || !aligned || !writable);
      if (exp_we) model[idx] = wdata;
    end else begin
      exp_err = SLVERR && (!in_range || !aligned);
    end
  endfunction

  task automatic poke(input int k, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = k; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // One APB transfer; samples the response on the negedge where pready rises.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err, output logic we,
                          output int lat, output logic [NREGS-1:0][RW-1:0] snap);
    @(negedge clk);
    apb_if.psel_i = 1'b1; apb_if.penable_i = 1'b0;
    apb_if.pwrite_i = wr; apb_if.paddr_i = addr; apb_if.pwdata_i = wdata;
    @(negedge clk);
    apb_if.penable_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!apb_if.pready_o && lat < 5);
    rd = apb_if.prdata_o; err = apb_if.pslverr_o; we = we_w; snap = regs_o_w;
    apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0;
  endtask

  task automatic run_chk(input string name, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic exp_err, input logic exp_we);
    logic [31:0] rd;
    logic        err, we;
    int          lat;
    logic [NREGS-1:0][RW-1:0] snap;
    apb_xfer(wr, addr, wdata, rd, err, we, lat, snap);
    chk({name, "_latency"}, 32'(lat), 32'd1);
    if (!wr) chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_slverr"}, 32'(err), 32'(exp_err));
    chk({name, "_strobe"}, 32'(we), 32'(exp_we));
    @(negedge clk);
    chk({name, "_strobe_off"}, 32'(we_w), 32'd0);
    chk({name, "_pready_off"}, 32'(apb_if.pready_o), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_we;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] rd, erd;
    logic        err, we, eerr, ewe;
    int          lat;
    logic [NREGS-1:0][RW-1:0] snap;

    vecs[0]  = '{1'b1, 32'h00, 32'h0000_0003, 32'h0, 1'b0,   1'b1};
    vecs[1]  = '{1'b0, 32'h00, 32'h0,         32'h3, 1'b0,   1'b0};
    vecs[2]  = '{1'b1, 32'h04, 32'h0000_0100, 32'h0, 1'b0,   1'b1};
    vecs[3]  = '{1'b0, 32'h04, 32'h0,         32'h100, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h28, 32'hDEAD_BEEF, 32'h0, 1'b0,   1'b1};
    vecs[5]  = '{1'b0, 32'h28, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h2C, 32'hFFFF_FFFF, 32'h0, SLVERR, 1'b0};
    vecs[7]  = '{1'b0, 32'h2C, 32'h0,         32'h5, 1'b0,   1'b0};
    vecs[8]  = '{1'b0, 32'h30, 32'h0,         32'h0, SLVERR, 1'b0};
    vecs[9]  = '{1'b1, 32'h30, 32'h0000_1234, 32'h0, SLVERR, 1'b0};
    vecs[10] = '{1'b1, 32'h24, 32'h0000_0055, 32'h0, 1'b0,   1'b1};
    vecs[11] = '{1'b0, 32'h24, 32'h0,         32'h55, 1'b0,  1'b0};

    for (int k = 0; k < NREGS; k++) model[k] = 32'h0;
    model[11] = 32'h5;
    apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b0;
    apb_if.paddr_i = 32'h0; apb_if.pwdata_i = 32'h0;

    // Reset state, with a live core value that must not leak through.
    poke(11, 32'h5);
    @(negedge clk);
    chk("rst_pready",  32'(apb_if.pready_o),  32'd0);
    chk("rst_pslverr", 32'(apb_if.pslverr_o), 32'd0);
    chk("rst_prdata",  apb_if.prdata_o,       32'd0);
    chk("rst_strobe",  32'(we_w),             32'd0);
    chk("rst_regs11",  regs_o_w[11],          32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("mirror_regs11", regs_o_w[11], 32'h5);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      run_chk($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_we);
      model_step(vecs[i].wr, vecs[i].addr, vecs[i].wdata, erd, eerr, ewe);
    end
    chk("cfg_regs0", regs_o_w[0], 32'h3);
    chk("vect_regs11", regs_o_w[11], 32'h5);

    // Write a counter while its event is counting: bus value must be loaded.
    @(negedge clk); ev1 = 1'b1;
    apb_xfer(1'b1, 32'h04, 32'h0000_0100, rd, err, we, lat, snap);
    chk("ev_strobe", 32'(we), 32'd1);
    chk("ev_regs1_during_strobe", snap[1], 32'h100);
    repeat (3) @(negedge clk);
    apb_xfer(1'b0, 32'h04, 32'h0, rd, err, we, lat, snap);
    chk("ev_read_ge_written", 32'(rd >= 32'h100), 32'd1);
    @(negedge clk); ev1 = 1'b0;
    model_step(1'b1, 32'h04, 32'h40, erd, eerr, ewe);
    run_chk("ev_rewrite", 1'b1, 32'h04, 32'h40, erd, eerr, ewe);

    // Reset in the wait state of a write aborts it without commit.
    @(negedge clk);
    apb_if.psel_i = 1'b1; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b1;
    apb_if.paddr_i = 32'h00; apb_if.pwdata_i = 32'hAA;
    @(negedge clk);
    apb_if.penable_i = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_rst_pready", 32'(apb_if.pready_o), 32'd0);
    chk("abort_rst_strobe", 32'(we_w), 32'd0);
    chk("abort_rst_regs0",  regs_o_w[0], 32'd0);
    apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0;
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_post_strobe%0d", c), 32'(we_w), 32'd0);
      chk($sformatf("abort_post_pready%0d", c), 32'(apb_if.pready_o), 32'd0);
    end
    chk("abort_regs0_restored", regs_o_w[0], model[0]);
    model_step(1'b0, 32'h00, 32'h0, erd, eerr, ewe);
    run_chk("abort_read0", 1'b0, 32'h00, 32'h0, erd, eerr, ewe);

    // psel dropped during the wait state: back to idle, no effect.
    @(negedge clk);
    apb_if.psel_i = 1'b1; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b1;
    apb_if.paddr_i = 32'h00; apb_if.pwdata_i = 32'h77;
    @(negedge clk);
    apb_if.psel_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("drop_strobe%0d", c), 32'(we_w), 32'd0);
      chk($sformatf("drop_pready%0d", c), 32'(apb_if.pready_o), 32'd0);
    end
    model_step(1'b0, 32'h00, 32'h0, erd, eerr, ewe);
    run_chk("drop_read0", 1'b0, 32'h00, 32'h0, erd, eerr, ewe);

    // Randomized transfers and core-side updates against the model.
    for (int i = 0; i < 40; i++) begin
      logic        wr;
      logic [31:0] addr, wdata;
      int          idx, lsb;
      if ($urandom_range(0, 3) == 0) begin
        int          k = $urandom_range(0, NREGS - 1);
        logic [31:0] v = $urandom;
        poke(k, v);
        model[k] = v;
      end
      wr    = 1'($urandom_range(0, 1));
      idx   = $urandom_range(0, 13);
      lsb   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      addr  = 32'(idx * 4 + lsb);
      wdata = $urandom;
      model_step(wr, addr, wdata, erd, eerr, ewe);
      run_chk($sformatf("rnd%0d", i), wr, addr, wdata, erd, eerr, ewe);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pmu_apb_regs.md
PMU_APB_REGS -- requirements
Module: pmu_apb_regs

Interface
REQ-001 Parameter REG_WIDTH, default 32, SHALL set register and APB data width.
REQ-002 Parameter N_COUNTERS, default 9, SHALL set number of event counter registers.
REQ-003 Parameter N_CONF_REGS, default 1, SHALL set number of configuration registers.
REQ-004 Parameter OVERFLOW, default 1, SHALL include (1) or omit (0) overflow mask/vector registers.
REQ-005 Parameter ADDR_WIDTH, default 32, SHALL set paddr_i width.
REQ-006 Derived TOTAL_NREGS SHALL equal N_CONF_REGS + N_COUNTERS + 2*ceil(N_COUNTERS/REG_WIDTH)*OVERFLOW (12 at defaults).
REQ-007 clk_i  in  1  clock, all logic rising-edge.
REQ-008 rstn_i  in  1  reset, asynchronous, active-low.
REQ-009 psel_i, penable_i, pwrite_i  in  1 each  APB3 select, enable, direction.
REQ-010 paddr_i  in  ADDR_WIDTH  byte address; pwdata_i  in  REG_WIDTH  write data.
REQ-011 prdata_o  out  REG_WIDTH; pready_o  out  1; pslverr_o  out  1.
REQ-012 regs_o  out  REG_WIDTH x TOTAL_NREGS  register file driven to the PMU core.
REQ-013 regs_i  in  REG_WIDTH x TOTAL_NREGS  live values returned by the PMU core.
REQ-014 wrapper_we_o  out  1  one-cycle strobe telling the PMU core to load regs_o.

Function
REQ-015 Register index SHALL be paddr_i[ADDR_WIDTH-1:2]; map: 0..N_CONF_REGS-1 config, then counters, then overflow mask, then overflow vector (defaults: 0x00 cfg, 0x04-0x24 counters, 0x28 mask, 0x2C vector).
REQ-016 FSM states IDLE, WAIT, RESP: IDLE->WAIT on psel_i&&!penable_i (latch index, pwrite_i, pwdata_i); WAIT->RESP unconditionally if psel_i&&penable_i, else ->IDLE with no effect; RESP->IDLE.
REQ-017 pready_o SHALL be 1 only in RESP (exactly one wait state); pslverr_o and prdata_o valid while pready_o=1.
REQ-018 On WAIT->RESP of a read, prdata_o SHALL register slv_reg[index]; out-of-range index returns 0.
REQ-019 On WAIT->RESP of a write to a writable in-range index, slv_reg[index] SHALL take pwdata_i and wrapper_we_o SHALL be 1 in the following (RESP) cycle only.
REQ-020 Overflow vector registers SHALL be read-only; writes to them or out of range SHALL not modify slv_reg nor assert wrapper_we_o.
REQ-021 Each cycle wrapper_we_o=0 and no commit occurs, every slv_reg[k] SHALL load regs_i[k] (mirror).
REQ-022 While wrapper_we_o=1, mirroring SHALL be suspended so the PMU loads the written value.
REQ-023 Commit coinciding with a PMU counter update: the bus write SHALL win.
REQ-024 regs_o[k] SHALL equal slv_reg[k] combinationally.

Reset
REQ-025 rstn_i low SHALL force state IDLE, all slv_reg 0, prdata_o 0, pready_o 0, pslverr_o 0, wrapper_we_o 0, aborting any transfer without commit.

Configuration
REQ-026 Macro PMU_APB_SLVERR_EN defined: pslverr_o SHALL be 1 in RESP for out-of-range index, paddr_i[1:0]!=0, or write to read-only register.
REQ-027 PMU_APB_SLVERR_EN undefined: pslverr_o SHALL be tied 0, paddr_i[1:0] ignored, illegal accesses silently dropped.

Structure
REQ-028 Package pmu_pkg SHALL hold register-map localparams (BASE_CFG, BASE_COUNTERS, BASE_OVERFLOW_MASK, BASE_OVERFLOW_VECT, TOTAL_NREGS function) shared with the PMU core, and the FSM state enum typedef.
REQ-029 One sub-module pmu_apb_fsm SHALL implement REQ-016/017 and emit commit/read-capture strobes; register file stays in top.

Verification
REQ-030 Write 0x0000_0003 to 0x00 -> pready_o high one cycle after access start, wrapper_we_o pulse 1 cycle, regs_o[0]=0x3.
REQ-031 Write 0x0000_0100 to 0x04 while event 0 active -> regs_o[1]=0x100 during strobe; later read of 0x04 returns >=0x100.
REQ-032 Read 0x2C with regs_i[11]=0x0000_0005 -> prdata_o=0x5, pslverr_o=0; write 0xFFFF_FFFF to 0x2C -> no strobe, slv_reg[11] unchanged, pslverr_o=1 iff macro defined.
REQ-033 Read 0x30 -> prdata_o=0, pslverr_o=1 (macro) / 0 (no macro).
REQ-034 Assert rstn_i low in WAIT of write 0xAA to 0x00 -> no strobe, regs_o[0]=0, pready_o=0, state IDLE.
REQ-035 Drop psel_i in WAIT -> return IDLE, no pready_o, no commit.
